ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage directly upstream of the memory stage, in the RSA decryption ASIP.
//  Performs single-cycle ALU ops and an iterative modular multiply (a*b mod m),
//  the core operation of RSA decryption. Ends in the EX/MEM pipeline register
//  whose address/write_data/mem_write outputs drive the memory stage.
//  Stalls upstream while a modular multiply is in progress.
// PARAMETERS
//  N   32   datapath width in bits (N >= 2); iteration counter is $clog2(N) bits
// PORTS
//  clk            in   1    clock, all state updates on rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  valid_in       in   1    upstream instruction valid
//  flush          in   1    kill in-flight op and output slot (branch/redirect)
//  alu_ctrl       in   3    000 ADD,001 SUB,010 AND,011 OR,100 SLL,101 SRL,110 MODMUL,111 PASSB
//  src_a          in   N    operand A
//  src_b          in   N    operand B (shift amount = src_b[4:0] for SLL/SRL)
//  src_m          in   N    modulus for MODMUL
//  store_data     in   N    data for store instructions
//  mem_write_in   in   1    instruction writes memory
//  reg_write_in   in   1    instruction writes register file
//  rd_in          in   5    destination register
//  stall          out  1    upstream must hold all inputs this cycle (combinational)
//  valid_out      out  1    EX/MEM slot valid
//  alu_result     out  N    result / memory address to memory stage
//  write_data     out  N    registered store_data to memory stage
//  mem_write_out  out  1    mem_write_in & valid_out
//  reg_write_out  out  1    reg_write_in & valid_out
//  rd_out         out  5    registered rd_in
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, counter=0, all outputs 0, stall=0.
//  - FSM: IDLE, BUSY. stall = (IDLE & valid_in & op==MODMUL & ~flush) | (BUSY & cnt!=0).
//  - IDLE, non-MODMUL valid op: result computed combinationally, registered at next
//    edge with valid_out=1 (latency 1). valid_in=0 -> bubble: valid_out=0, controls 0.
//  - Arithmetic modulo 2^N (ADD/SUB wrap, no flags). Shifts logical, zero fill.
//  - IDLE, valid MODMUL: latch a,b,m; P=0; cnt=N-1; go BUSY; output slot gets bubble.
//  - BUSY, one bit/cycle, i=cnt from MSB: P=2P; if P>=m P-=m; if b[i] P+=a;
//    if P>=m P-=m. P held in N+1 bits. Operand contract: a<m, b<m.
//  - BUSY & cnt==0: final iteration; at that edge alu_result=P[N-1:0], valid_out=1
//    with the held controls; state->IDLE. stall low in this cycle so upstream advances.
//  - MODMUL total: stall high N cycles, result valid N+1 edges after acceptance.
//  - m==0: same latency, alu_result=0.
//  - Output slot during BUSY (other than final edge): valid_out=0, controls 0.
//  - flush (priority over all): at next edge state->IDLE, valid_out=0, controls 0;
//    stall forced 0 in the cycle flush is high; operand registers may hold stale data.
//  - Reset mid-BUSY: immediate abort, outputs 0; no partial result ever emitted.
//  - Back-to-back: new instruction accepted in the cycle after MODMUL result edge.
// TESTING
//  1 ADD a=5,b=7 valid -> next edge alu_result=12, valid_out=1, stall never high.
//  2 SUB a=0,b=1 -> alu_result=32'hFFFF_FFFF; SLL a=1,b=35 -> 32'h8 (amount=3).
//  3 MODMUL a=10,b=20,m=13 -> stall high 32 cycles, result 5 valid on edge 33, then
//    following ADD 1+1 produces 2 one edge later.
//  4 MODMUL a=3,b=5,m=7 -> 1; m=0 -> 0 with same 33-edge latency.
//  5 flush asserted in 10th BUSY cycle -> valid_out stays 0, stall low next cycle,
//    FSM in IDLE; following ADD completes with latency 1.
//  6 rst_n low mid-BUSY with mem_write_in=1 -> all outputs 0 immediately, no
//    mem_write_out pulse after release; random MODMUL vs. golden model (a,b<m) match.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a bit-serial a*b mod m, closed by the EX/MEM register.
// Latency 1 edge for ALU ops and N+1 edges for MODMUL; stall is held while the multiply iterates and is dropped by flush.
module ex_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic         flush,
  input  logic [2:0]   alu_ctrl,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic [N-1:0] src_m,
  input  logic [N-1:0] store_data,
  input  logic         mem_write_in,
  input  logic         reg_write_in,
  input  logic [4:0]   rd_in,
  output logic         stall,
  output logic         valid_out,
  output logic [N-1:0] alu_result,
  output logic [N-1:0] write_data,
  output logic         mem_write_out,
  output logic         reg_write_out,
  output logic [4:0]   rd_out
);
  localparam int CW = $clog2(N);
  localparam int SW = (N < 5) ? N : 5;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRL    = 3'b101;
  localparam logic [2:0] OP_MODMUL = 3'b110;
  localparam logic [2:0] OP_PASSB  = 3'b111;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d, sd_q, sd_d;
  logic          hmw_q, hmw_d, hrw_q, hrw_d;
  logic [4:0]    hrd_q, hrd_d;
  logic          vld_q, vld_d, mw_q, mw_d, rw_q, rw_d;
  logic [N-1:0]  res_q, res_d, wd_q, wd_d;
  logic [4:0]    rd_q, rd_d;

  logic [N-1:0]  alu_res;
  logic [N:0]    mx, p2, p3, p4;
  logic [N-1:0]  p5;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_ADD:   alu_res = src_a + src_b;
      OP_SUB:   alu_res = src_a - src_b;
      OP_AND:   alu_res = src_a & src_b;
      OP_OR:    alu_res = src_a | src_b;
      OP_SLL:   alu_res = src_a << src_b[SW-1:0];
      OP_SRL:   alu_res = src_a >> src_b[SW-1:0];
      OP_PASSB: alu_res = src_b;
      default:  alu_res = '0;
    endcase
  end

  // One interleaved step: P stays below m, so each partial sum fits in N+1 bits.
  assign mx = {1'b0, m_q};
  assign p2 = {p_q, 1'b0};
  assign p3 = (p2 >= mx) ? p2 - mx : p2;
  assign p4 = b_q[cnt_q] ? p3 + {1'b0, a_q} : p3;
  assign p5 = (p4 >= mx) ? N'(p4 - mx) : p4[N-1:0];

  assign stall = rst_n & ~flush &
                 (((state_q == IDLE) & valid_in & (alu_ctrl == OP_MODMUL)) |
                  ((state_q == BUSY) & (cnt_q != '0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    sd_d    = sd_q;
    hmw_d   = hmw_q;
    hrw_d   = hrw_q;
    hrd_d   = hrd_q;
    vld_d   = 1'b0;
    res_d   = '0;
    wd_d    = '0;
    mw_d    = 1'b0;
    rw_d    = 1'b0;
    rd_d    = '0;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (valid_in && alu_ctrl == OP_MODMUL) begin
        a_d     = src_a;
        b_d     = src_b;
        m_d     = src_m;
        p_d     = '0;
        sd_d    = store_data;
        hmw_d   = mem_write_in;
        hrw_d   = reg_write_in;
        hrd_d   = rd_in;
        cnt_d   = CW'(N - 1);
        state_d = BUSY;
      end else if (valid_in) begin
        vld_d = 1'b1;
        res_d = alu_res;
        wd_d  = store_data;
        mw_d  = mem_write_in;
        rw_d  = reg_write_in;
        rd_d  = rd_in;
      end
    end else begin
      p_d   = p5;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = IDLE;
        vld_d   = 1'b1;
        res_d   = (m_q == '0) ? '0 : p5;
        wd_d    = sd_q;
        mw_d    = hmw_q;
        rw_d    = hrw_q;
        rd_d    = hrd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      sd_q    <= '0;
      hmw_q   <= 1'b0;
      hrw_q   <= 1'b0;
      hrd_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      wd_q    <= '0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      sd_q    <= sd_d;
      hmw_q   <= hmw_d;
      hrw_q   <= hrw_d;
      hrd_q   <= hrd_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      wd_q    <= wd_d;
      mw_q    <= mw_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
    end
  end

  assign valid_out     = vld_q;
  assign alu_result    = res_q;
  assign write_data    = wd_q;
  assign mem_write_out = mw_q;
  assign reg_write_out = rw_q;
  assign rd_out        = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: transaction-level reference model plus per-cycle compare, directed and random traffic.
module tb_ex_stage;
  localparam int N = 32;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_SLL = 3'd4, OP_SRL = 3'd5, OP_MOD = 3'd6, OP_PASSB = 3'd7;

  logic         clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, flush = 1'b0;
  logic [2:0]   alu_ctrl = '0;
  logic [N-1:0] src_a = '0, src_b = '0, src_m = '0, store_data = '0;
  logic         mem_write_in = 1'b0, reg_write_in = 1'b0;
  logic [4:0]   rd_in = '0;
  logic         stall, valid_out, mem_write_out, reg_write_out;
  logic [N-1:0] alu_result, write_data;
  logic [4:0]   rd_out;

  ex_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .src_m(src_m), .store_data(store_data),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
    .stall(stall), .valid_out(valid_out), .alu_result(alu_result), .write_data(write_data),
    .mem_write_out(mem_write_out), .reg_write_out(reg_write_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input logic [2:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic [N-1:0] m);
    logic [63:0] prod;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLL:  return a << (b % 32);
      OP_SRL:  return a >> (b % 32);
      OP_MOD: begin
        if (m == 0) return '0;
        prod = ({32'b0, a} * {32'b0, b}) % {32'b0, m};
        return prod[N-1:0];
      end
      default: return b;
    endcase
  endfunction

  // Reference model: rem = multiply cycles still to run; result appears when it reaches 0.
  int           rem = 0;
  logic         e_vld = 1'b0, e_mw = 1'b0, e_rw = 1'b0;
  logic [N-1:0] e_res = '0, e_wd = '0;
  logic [4:0]   e_rd = '0;
  logic [N-1:0] pd_res = '0, pd_wd = '0;
  logic         pd_mw = 1'b0, pd_rw = 1'b0;
  logic [4:0]   pd_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0; e_vld = 0; e_mw = 0; e_rw = 0; e_res = '0; e_wd = '0; e_rd = '0;
    end else begin
      e_vld = 0; e_mw = 0; e_rw = 0; e_res = '0; e_wd = '0; e_rd = '0;
      if (flush) rem = 0;
      else if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          e_vld = 1; e_res = pd_res; e_wd = pd_wd; e_mw = pd_mw; e_rw = pd_rw; e_rd = pd_rd;
        end
      end else if (valid_in) begin
        if (alu_ctrl == OP_MOD) begin
          pd_res = ref_op(OP_MOD, src_a, src_b, src_m);
          pd_wd = store_data; pd_mw = mem_write_in; pd_rw = reg_write_in; pd_rd = rd_in;
          rem = N;
        end else begin
          e_vld = 1; e_res = ref_op(alu_ctrl, src_a, src_b, src_m);
          e_wd = store_data; e_mw = mem_write_in; e_rw = reg_write_in; e_rd = rd_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    e_stall = rst_n && !flush && ((rem == 0 && valid_in && alu_ctrl == OP_MOD) || rem > 1);
    chk("stall", stall, e_stall);
    chk("valid_out", valid_out, e_vld);
    chk("mem_write_out", mem_write_out, e_mw);
    chk("reg_write_out", reg_write_out, e_rw);
    if (e_vld) begin
      chk("alu_result", alu_result, e_res);
      chk("write_data", write_data, e_wd);
      chk("rd_out", rd_out, e_rd);
    end
  end

  // Present one instruction and hold it while stall is high; flush_at = hold cycle to redirect in.
  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] m, input logic [N-1:0] sd, input logic mw,
                       input logic rw, input logic [4:0] rd, input int flush_at,
                       output int nstall, output int nedge);
    logic s, f, done;
    valid_in = 1; alu_ctrl = op; src_a = a; src_b = b; src_m = m;
    store_data = sd; mem_write_in = mw; reg_write_in = rw; rd_in = rd;
    nstall = 0; nedge = 0; done = 0;
    for (int k = 0; k < N + 8; k++) begin
      if (k == flush_at) flush = 1;
      @(negedge clk);
      s = stall; f = flush;
      if (s) nstall++;
      @(posedge clk); #1;
      nedge++;
      flush = 0;
      if (f || !s) begin
        done = 1;
        break;
      end
    end
    chk("issue_accepted_in_budget", done, 1);
    valid_in = 0; flush = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ns, ne, sel, fl;
    logic [2:0] op;
    logic [N-1:0] a, b, m;
    logic mw_seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_stall", stall, 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_mem_write_out", mem_write_out, 0);
    rst_n = 1;
    @(posedge clk); #1;

    issue(OP_ADD, 5, 7, 0, 32'hAA, 1, 0, 5'd3, -1, ns, ne);
    chk("add_result", alu_result, 12);
    chk("add_valid", valid_out, 1);
    chk("add_no_stall", ns, 0);
    chk("add_latency", ne, 1);
    chk("add_mem_write_out", mem_write_out, 1);
    issue(OP_SUB, 0, 1, 0, 0, 0, 1, 5'd1, -1, ns, ne);
    chk("sub_wrap", alu_result, 32'hFFFF_FFFF);
    issue(OP_SLL, 1, 35, 0, 0, 0, 1, 5'd2, -1, ns, ne);
    chk("sll_amount3", alu_result, 32'h8);
    issue(OP_SRL, 32'h8000_0000, 31, 0, 0, 0, 1, 5'd2, -1, ns, ne);
    chk("srl_31", alu_result, 1);
    issue(OP_AND, 32'hF0F0, 32'hFF00, 0, 0, 0, 1, 5'd2, -1, ns, ne);
    chk("and", alu_result, 32'hF000);
    issue(OP_PASSB, 9, 123, 0, 0, 0, 1, 5'd2, -1, ns, ne);
    chk("passb", alu_result, 123);

    issue(OP_MOD, 10, 20, 13, 32'h55, 0, 1, 5'd7, -1, ns, ne);
    chk("mod_stall_cycles", ns, 32);
    chk("mod_result_edge", ne, 33);
    chk("mod_result", alu_result, 5);
    chk("mod_valid", valid_out, 1);
    chk("mod_rd_out", rd_out, 7);
    issue(OP_ADD, 1, 1, 0, 0, 0, 1, 5'd8, -1, ns, ne);
    chk("b2b_add_latency", ne, 1);
    chk("b2b_add_result", alu_result, 2);

    issue(OP_MOD, 3, 5, 7, 0, 0, 1, 5'd4, -1, ns, ne);
    chk("mod_3_5_7", alu_result, 1);
    issue(OP_MOD, 9, 4, 0, 0, 0, 1, 5'd4, -1, ns, ne);
    chk("mod_m0_result", alu_result, 0);
    chk("mod_m0_edge", ne, 33);

    issue(OP_MOD, 10, 20, 13, 0, 1, 1, 5'd9, 10, ns, ne);
    chk("flush_valid_out", valid_out, 0);
    chk("flush_stall_before", ns, 10);
    @(negedge clk);
    chk("flush_stall_after", stall, 0);
    @(posedge clk); #1;
    issue(OP_ADD, 4, 6, 0, 0, 0, 1, 5'd1, -1, ns, ne);
    chk("post_flush_add_latency", ne, 1);
    chk("post_flush_add_result", alu_result, 10);

    valid_in = 1; alu_ctrl = OP_MOD; src_a = 2; src_b = 3; src_m = 11;
    mem_write_in = 1; reg_write_in = 1; rd_in = 5'd6; store_data = 32'h1234;
    repeat (6) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rstbusy_valid_out", valid_out, 0);
    chk("rstbusy_mem_write_out", mem_write_out, 0);
    chk("rstbusy_alu_result", alu_result, 0);
    chk("rstbusy_stall", stall, 0);
    valid_in = 0;
    @(posedge clk); #1 rst_n = 1;
    mw_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_write_out || valid_out) mw_seen = 1;
    end
    chk("rstbusy_no_late_pulse", mw_seen, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        valid_in = 0;
        @(posedge clk); #1;
      end else begin
        op = 3'($urandom_range(0, 7));
        a = $urandom; b = $urandom; m = $urandom;
        if ($urandom_range(0, 2) == 0) op = OP_MOD;
        if (op == OP_MOD) begin
          sel = $urandom_range(0, 7);
          if (sel == 0) m = 0;
          else begin
            if (sel < 3) m = $urandom_range(1, 20);
            else if (m == 0) m = 1;
            a = $urandom % m;
            b = $urandom % m;
          end
        end
        fl = -1;
        if ($urandom_range(0, 15) == 0) fl = (op == OP_MOD) ? $urandom_range(0, N) : 0;
        issue(op, a, b, m, $urandom, 1'($urandom), 1'($urandom), 5'($urandom), fl, ns, ne);
      end
    end

    valid_in = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
